// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg: stage state encoding and occupancy counter sizing shared by the pipeline.
package elastic_pipeline_pkg;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} stage_state_t;
    function automatic int count_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction
endpackage

// File: rtl/elastic_pipeline_skid.sv
// skid_stage: one registered pipeline stage with a skid register and a registered ready.
module skid_stage
    import elastic_pipeline_pkg::*;
#(
    parameter int p_width = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [p_width-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [p_width-1:0] m_data
);
    stage_state_t state_q, state_d;
    logic [p_width-1:0] main_q, main_d, skid_q, skid_d;
    logic ready_q, in_x, out_x;
    assign s_ready = ready_q;
    assign m_valid = state_q != EMPTY;
    assign m_data  = main_q;
    assign in_x    = s_valid && ready_q;
    assign out_x   = m_valid && m_ready;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_x) begin
                state_d = BUSY;
                main_d  = s_data;
            end
            BUSY: if (in_x && !out_x) begin
                state_d = FULL;
                skid_d  = s_data;
            end else if (out_x && !in_x) begin
                state_d = EMPTY;
            end else if (in_x) begin
                main_d = s_data;
            end
            FULL: if (out_x) begin
                state_d = BUSY;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
    end
    // ready is registered from the next state, so it never depends on m_ready combinationally
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= state_d != FULL;
        end
    end
endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: chain of skid stages with valid/ready at both ends and an occupancy counter.
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int p_width  = 32,
    parameter int p_stages = 3
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [p_width-1:0]                 i_data,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [p_width-1:0]                 o_data,
    output logic [count_width(p_stages)-1:0]   o_count
);
    localparam int cw = count_width(p_stages);
    logic               v [p_stages+1];
    logic               r [p_stages+1];
    logic [p_width-1:0] d [p_stages+1];
    logic [cw-1:0]      count_q, count_d;
    logic               in_x, out_x;
    assign v[0]         = i_valid;
    assign d[0]         = i_data;
    assign r[p_stages]  = i_ready;
    assign o_ready      = r[0];
    assign o_valid      = v[p_stages];
    assign o_data       = d[p_stages];
    assign o_count      = count_q;
    genvar k;
    generate
        for (k = 0; k < p_stages; k++) begin : g_stage
            skid_stage #(.p_width(p_width)) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .s_valid (v[k]),
                .s_ready (r[k]),
                .s_data  (d[k]),
                .m_valid (v[k+1]),
                .m_ready (r[k+1]),
                .m_data  (d[k+1])
            );
        end
    endgenerate
    assign in_x    = i_valid && o_ready;
    assign out_x   = o_valid && i_ready;
    assign count_d = (in_x && !out_x) ? count_q + cw'(1) :
                     (out_x && !in_x) ? count_q - cw'(1) : count_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed and scoreboarded random checks of the 3-stage, 32-bit elastic pipeline.
module tb_elastic_pipeline;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
    logic        o_ready, o_valid;
    logic [31:0] i_data = '0, o_data;
    logic [2:0]  o_count;
    int tests = 0, fails = 0;
    always #5 i_clk = ~i_clk;
    elastic_pipeline #(.p_width(32), .p_stages(3)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask
    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] q[$];
        logic [31:0] held;
        logic        stall, a, in_x, out_x;
        int          acc, sent, model, cyc;
        repeat (3) tick;
        check("rst_valid", o_valid, 0);
        check("rst_count", o_count, 0);
        check("rst_ready", o_ready, 0);
        check("rst_data", o_data, 0);
        i_rst = 1'b0;
        check("rdy_pre", o_ready, 0);
        tick;
        check("rdy_post", o_ready, 1);
        i_ready = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            i_valid = c <= 8;
            i_data  = 32'(c);
            tick;
            check("s_valid", o_valid, 64'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) check("s_data", o_data, 64'(c - 2));
            check("s_count", o_count, 64'(c <= 3 ? c : c <= 8 ? 3 : 11 - c));
            check("s_ready", o_ready, 1);
        end
        i_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 12; n++) begin
            i_valid = 1'b1;
            i_data  = 32'h10 + 32'(acc);
            a = o_ready;
            tick;
            if (a) acc++;
            if (o_valid) check("stall_hold", o_data, 'h10);
        end
        check("fill_acc", acc, 6);
        check("fill_ready", o_ready, 0);
        check("fill_count", o_count, 6);
        check("fill_data", o_data, 'h10);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            check("d_valid", o_valid, 64'(c < 6));
            if (c < 6) check("d_data", o_data, 64'(32'h10 + 32'(c)));
            check("d_count", o_count, 64'(6 - c));
            check("d_ready", o_ready, 64'(c >= 3));
        end
        sent = 0; model = 0; cyc = 0; stall = 1'b0; held = '0;
        while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
            i_valid = sent < 10000 && $urandom_range(1, 0) == 1;
            i_data  = 32'h100 + 32'(sent);
            i_ready = $urandom_range(1, 0) == 1;
            in_x  = i_valid && o_ready;
            out_x = o_valid && i_ready;
            if (stall) check("r_hold", o_data, held);
            if (out_x) begin
                if (q.size() == 0) check("r_spurious", o_valid, 0);
                else check("r_order", o_data, q.pop_front());
            end
            if (in_x) begin
                q.push_back(i_data);
                sent++;
            end
            model += int'(in_x) - int'(out_x);
            stall = o_valid && !i_ready;
            held  = o_data;
            tick;
            cyc++;
            check("r_count", o_count, 64'(model));
        end
        check("r_done", 64'(sent == 10000 && q.size() == 0), 1);
        i_valid = 1'b0;
        i_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 10 && acc < 4; n++) begin
            i_valid = 1'b1;
            i_data  = 32'h40 + 32'(acc);
            a = o_ready;
            tick;
            if (a) acc++;
        end
        i_valid = 1'b0;
        check("m_count", o_count, 4);
        check("m_valid", o_valid, 1);
        #2 i_rst = 1'b1;
        #1;
        check("m_rst_valid", o_valid, 0);
        check("m_rst_count", o_count, 0);
        check("m_rst_ready", o_ready, 0);
        tick;
        tick;
        i_rst = 1'b0;
        tick;
        check("m_ready", o_ready, 1);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hAB;
        tick;
        i_valid = 1'b0;
        for (int n = 0; n < 10 && !o_valid; n++) tick;
        check("ab_valid", o_valid, 1);
        check("ab_data", o_data, 'hAB);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
